// File: rtl/lsu_mem_port_if.sv
// Request/response and DataM signals of the load/store port, bundled for lsu_mem_port.
// master = core plus DataM side, slave = the LSU itself.
interface lsu_mem_port_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic [31:0] ReadData;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, ReadData,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, Address, WriteData, MemWrite
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, ReadData,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, Address, WriteData, MemWrite
  );
endinterface

// File: rtl/lsu_mem_port.sv
// Load/store initiator for a word-wide DataM; SB/SH done as read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of force-aligning them.
module lsu_mem_port #(
  parameter int unsigned MEM_RD_LAT = 1
) (
  input logic           CLK,
  input logic           RST,
  lsu_mem_port_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

  localparam logic [1:0] RdLast = 2'(MEM_RD_LAT - 1);

  state_e      state_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic [1:0]  cnt_q;

  logic        req_bad;
  logic [31:0] req_addr_eff;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_val;
  logic [31:0] merged;

  always_comb begin
    req_addr_eff = bus.req_addr;
    req_bad      = bus.req_we ? (bus.req_funct3 > 3'b010)
                              : (bus.req_funct3 == 3'b011 || bus.req_funct3[2:1] == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
    case (bus.req_funct3[1:0])
      2'b01:   req_bad = req_bad | bus.req_addr[0];
      2'b10:   req_bad = req_bad | (|bus.req_addr[1:0]);
      default: ;
    endcase
`else
    case (bus.req_funct3[1:0])
      2'b01:   req_addr_eff[0]   = 1'b0;
      2'b10:   req_addr_eff[1:0] = 2'b00;
      default: ;
    endcase
`endif
  end

  // Lane extraction for loads and lane replacement for SB/SH, both on the live ReadData.
  always_comb begin
    ld_b = bus.ReadData[{lane_q, 3'b000} +: 8];
    ld_h = bus.ReadData[{lane_q[1], 4'b0000} +: 16];
    case (f3_q)
      3'b000:  ld_val = {{24{ld_b[7]}}, ld_b};
      3'b001:  ld_val = {{16{ld_h[15]}}, ld_h};
      3'b100:  ld_val = {24'h0, ld_b};
      3'b101:  ld_val = {16'h0, ld_h};
      default: ld_val = bus.ReadData;
    endcase
    merged = bus.ReadData;
    if (f3_q[0]) merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
    else         merged[{lane_q, 3'b000} +: 8]      = wdata_q[7:0];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= StIdle;
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 32'h0;
      bus.rsp_err   <= 1'b0;
      bus.Address   <= 32'h0;
      bus.WriteData <= 32'h0;
      bus.MemWrite  <= 1'b0;
      we_q          <= 1'b0;
      f3_q          <= 3'b000;
      lane_q        <= 2'b00;
      wdata_q       <= 16'h0;
      cnt_q         <= 2'b00;
    end else begin
      bus.rsp_valid <= 1'b0;
      bus.MemWrite  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          bus.req_ready <= 1'b1;
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            we_q          <= bus.req_we;
            f3_q          <= bus.req_funct3;
            lane_q        <= req_addr_eff[1:0];
            wdata_q       <= bus.req_wdata[15:0];
            cnt_q         <= 2'b00;
            if (req_bad) begin
              state_q       <= StResp;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_rdata <= 32'h0;
            end else if (bus.req_we && bus.req_funct3 == 3'b010) begin
              state_q       <= StWr;
              bus.Address   <= {req_addr_eff[31:2], 2'b00};
              bus.WriteData <= bus.req_wdata;
              bus.MemWrite  <= 1'b1;
            end else begin
              state_q     <= StRd;
              bus.Address <= {req_addr_eff[31:2], 2'b00};
            end
          end
        end
        StRd: begin
          if (cnt_q == RdLast) begin
            if (we_q) begin
              state_q       <= StWr;
              bus.WriteData <= merged;
              bus.MemWrite  <= 1'b1;
            end else begin
              state_q       <= StResp;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b0;
              bus.rsp_rdata <= ld_val;
            end
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        StWr: begin
          state_q       <= StResp;
          bus.rsp_valid <= 1'b1;
          bus.rsp_err   <= 1'b0;
          bus.rsp_rdata <= 32'h0;
        end
        StResp: begin
          state_q       <= StIdle;
          bus.req_ready <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: directed cases plus random traffic against a byte-level memory model.
module tb_lsu_mem_port;
  localparam int LAT = 1;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   total = 0;
  int   bad   = 0;

  lsu_mem_port_if bus ();

  lsu_mem_port #(.MEM_RD_LAT(LAT)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // DataM: word array, combinational read for latency 1, one register stage for latency 2.
  logic [31:0] dmem [0:63];
  always @(posedge CLK) if (bus.MemWrite === 1'b1) dmem[bus.Address[7:2]] <= bus.WriteData;
  generate
    if (LAT == 1) begin : g_rd1
      assign bus.ReadData = dmem[bus.Address[7:2]];
    end else begin : g_rd2
      logic [31:0] rd_r;
      always @(posedge CLK) rd_r <= dmem[bus.Address[7:2]];
      assign bus.ReadData = rd_r;
    end
  endgenerate

  logic [7:0] ref_b [0:255];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output int e_lat, output logic [31:0] e_rd,
                       output logic e_err, output int e_nwr, output logic [31:0] e_wa,
                       output logic [31:0] e_wd);
    int size;
    logic illegal;
    logic [31:0] ea, v;
    illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
`ifdef LSU_MISALIGN_TRAP_EN
    if (addr % size != 0) illegal = 1'b1;
`endif
    ea = addr - (addr % size);
    e_nwr = 0; e_wa = 0; e_wd = 0; e_rd = 0; e_err = 1'b0;
    if (illegal) begin
      e_err = 1'b1;
      e_lat = 1;
    end else if (we) begin
      for (int i = 0; i < size; i++) ref_b[8'(ea + 32'(i))] = wd[8*i +: 8];
      e_nwr = 1;
      e_wa  = ea & ~32'd3;
      for (int i = 0; i < 4; i++) e_wd[8*i +: 8] = ref_b[8'(e_wa + 32'(i))];
      e_lat = (size == 4) ? 2 : LAT + 2;
    end else begin
      v = 0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = ref_b[8'(ea + 32'(i))];
      if (!f3[2] && size < 4 && v[8*size-1])
        for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
      e_rd  = v;
      e_lat = LAT + 1;
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic drive(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    @(posedge CLK); #1;
    // Scramble inputs after acceptance; the DUT must not look at them again.
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'($urandom);
    bus.req_funct3 = 3'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
  endtask

  task automatic run(input string tag, input bit we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd);
    int e_lat, e_nwr, lat, nwr;
    logic [31:0] e_rd, e_wa, e_wd, rd, wa, wdt;
    logic e_err, err;
    model(we, f3, addr, wd, e_lat, e_rd, e_err, e_nwr, e_wa, e_wd);
    wait_ready(tag);
    drive(we, f3, addr, wd);
    lat = 0; nwr = 0; wa = 0; wdt = 0; rd = 0; err = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) begin @(posedge CLK); #1; end
      if (bus.MemWrite === 1'b1) begin
        nwr++;
        wa  = bus.Address;
        wdt = bus.WriteData;
      end
      if (bus.rsp_valid === 1'b1) begin
        lat = c;
        rd  = bus.rsp_rdata;
        err = bus.rsp_err;
        break;
      end
    end
    chk({tag, "_lat"}, 32'(lat), 32'(e_lat));
    chk({tag, "_err"}, 32'(err), 32'(e_err));
    chk({tag, "_rdata"}, rd, e_rd);
    chk({tag, "_nwr"}, 32'(nwr), 32'(e_nwr));
    if (e_nwr == 1) begin
      chk({tag, "_waddr"}, wa, e_wa);
      chk({tag, "_wdata"}, wdt, e_wd);
    end
    @(posedge CLK); #1;
    chk({tag, "_pulse"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_hold"}, bus.rsp_rdata, e_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h10;
    bus.req_wdata  = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      chk("rst_memwrite", 32'(bus.MemWrite), 32'd0);
      chk("rst_rspvalid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_ready", 32'(bus.req_ready), 32'd0);
    end
    chk("rst_address", bus.Address, 32'h0);
    chk("rst_rdata", bus.rsp_rdata, 32'h0);
    RST = 1'b0;
    bus.req_valid = 1'b0;
    @(posedge CLK); #1;
    chk("rst_ready_after", 32'(bus.req_ready), 32'd1);

    run("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    run("lw10", 1'b0, 3'b010, 32'h10, 32'h0);
    run("sw10_init", 1'b1, 3'b010, 32'h10, 32'h11223344);
    run("sb13", 1'b1, 3'b000, 32'h13, 32'h000000A5);
    run("lb13", 1'b0, 3'b000, 32'h13, 32'h0);
    run("lbu13", 1'b0, 3'b100, 32'h13, 32'h0);
    run("sw10_init2", 1'b1, 3'b010, 32'h10, 32'h11223344);
    run("sh12", 1'b1, 3'b001, 32'h12, 32'h00008001);
    run("lh12", 1'b0, 3'b001, 32'h12, 32'h0);
    run("lhu12", 1'b0, 3'b101, 32'h12, 32'h0);
    run("st_illegal", 1'b1, 3'b011, 32'h10, 32'hFFFFFFFF);
    run("ld_illegal", 1'b0, 3'b110, 32'h10, 32'h0);
    run("lw13", 1'b0, 3'b010, 32'h13, 32'h0);
    run("lh11", 1'b0, 3'b001, 32'h11, 32'h0);

    // Reset during the write cycle of an SB read-modify-write.
    run("sw20_init", 1'b1, 3'b010, 32'h20, 32'hCAFEF00D);
    wait_ready("sb20");
    drive(1'b1, 3'b000, 32'h20, 32'h5A);
    for (int c = 0; c < 10 && bus.MemWrite !== 1'b1; c++) begin
      @(posedge CLK); #1;
    end
    chk("abort_wr_seen", 32'(bus.MemWrite), 32'd1);
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("abort_memwrite", 32'(bus.MemWrite), 32'd0);
    chk("abort_rspvalid", 32'(bus.rsp_valid), 32'd0);
    chk("abort_ready", 32'(bus.req_ready), 32'd0);
    RST = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      chk("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
      chk("abort_no_wr", 32'(bus.MemWrite), 32'd0);
    end
    chk("abort_idle", 32'(bus.req_ready), 32'd1);
    run("sw20_resync", 1'b1, 3'b010, 32'h20, 32'h0BADC0DE);
    run("lw20", 1'b0, 3'b010, 32'h20, 32'h0);

    for (int w = 0; w < 4; w++) run("rnd_init", 1'b1, 3'b010, 32'h40 + 32'(4*w), $urandom);
    for (int k = 0; k < 40; k++) begin
      run("rnd", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
          32'h40 + 32'($urandom_range(0, 15)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
